// File: rtl/des_align.sv
// Receive-side deserializer and K28.5 comma aligner: shifts in one bit per clock,
// locks onto symbol boundaries and emits aligned symbols with a valid strobe.
module des_align #(
  parameter int SYM_W       = 10,
  parameter int LOCK_COMMAS = 3,
  parameter int LOSS_COMMAS = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  output logic [SYM_W-1:0] sym_out,
  output logic             sym_valid,
  output logic             is_comma,
  output logic             locked,
  output logic             align_err
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  localparam logic [SYM_W-1:0] COMMA_NEG = SYM_W'(10'b0011111010);
  localparam logic [SYM_W-1:0] COMMA_POS = SYM_W'(10'b1100000101);
  localparam logic [CNT_W-1:0] LOCK_N    = CNT_W'(LOCK_COMMAS);
  localparam logic [CNT_W-1:0] LOSS_N    = CNT_W'(LOSS_COMMAS);

  state_t             state_reg, state_next;
  logic [SYM_W-1:0]   shreg_reg;
  logic [3:0]         ph_reg, ph_next;
  logic [CNT_W-1:0]   comma_cnt_reg, comma_cnt_next;
  logic [CNT_W-1:0]   err_cnt_reg, err_cnt_next;
  logic [SYM_W-1:0]   sym_out_reg, sym_out_next;
  logic               sym_valid_reg, sym_valid_next;
  logic               is_comma_reg, is_comma_next;
  logic               locked_reg, locked_next;
  logic               align_err_reg, align_err_next;

  logic               match;
  logic               boundary;
  logic               lose;
  logic [CNT_W-1:0]   comma_inc;
  logic [CNT_W-1:0]   err_inc;

  assign match     = (shreg_reg == COMMA_NEG) || (shreg_reg == COMMA_POS);
  assign boundary  = (ph_reg == 4'd9);
  assign comma_inc = comma_cnt_reg + 1'b1;
  assign err_inc   = err_cnt_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    ph_next        = boundary ? 4'd0 : ph_reg + 4'd1;
    comma_cnt_next = comma_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    sym_out_next   = sym_out_reg;
    sym_valid_next = 1'b0;
    is_comma_next  = 1'b0;
    align_err_next = 1'b0;
    lose           = 1'b0;

    case (state_reg)
      HUNT: begin
        if (match) begin
          sym_out_next   = shreg_reg;
          sym_valid_next = 1'b1;
          is_comma_next  = 1'b1;
          ph_next        = 4'd0;
          comma_cnt_next = CNT_W'(1);
          err_cnt_next   = '0;
          state_next     = (LOCK_COMMAS == 1) ? LOCKED : SYNC;
        end
      end
      SYNC: begin
        if (boundary) begin
          sym_out_next   = shreg_reg;
          sym_valid_next = 1'b1;
          is_comma_next  = match;
          if (match) begin
            comma_cnt_next = comma_inc;
            if (comma_inc == LOCK_N) begin
              state_next   = LOCKED;
              err_cnt_next = '0;
            end
          end
        end else if (match) begin
          // Comma at a new phase: restart the boundary count from this comma.
          sym_out_next   = shreg_reg;
          sym_valid_next = 1'b1;
          is_comma_next  = 1'b1;
          ph_next        = 4'd0;
          comma_cnt_next = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (boundary) begin
          sym_out_next   = shreg_reg;
          sym_valid_next = 1'b1;
          is_comma_next  = match;
          if (match) err_cnt_next = '0;
        end else if (match) begin
          align_err_next = 1'b1;
          err_cnt_next   = err_inc;
          if (err_inc == LOSS_N) begin
            state_next     = HUNT;
            ph_next        = 4'd0;
            comma_cnt_next = '0;
            err_cnt_next   = '0;
            lose           = 1'b1;
          end
        end
      end
      default: state_next = HUNT;
    endcase

    // Lock stays up through the final align_err pulse and drops the cycle after.
    locked_next = (state_next == LOCKED) || lose;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HUNT;
      shreg_reg     <= '0;
      ph_reg        <= '0;
      comma_cnt_reg <= '0;
      err_cnt_reg   <= '0;
      sym_out_reg   <= '0;
      sym_valid_reg <= 1'b0;
      is_comma_reg  <= 1'b0;
      locked_reg    <= 1'b0;
      align_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= {shreg_reg[SYM_W-2:0], serial_in};
      ph_reg        <= ph_next;
      comma_cnt_reg <= comma_cnt_next;
      err_cnt_reg   <= err_cnt_next;
      sym_out_reg   <= sym_out_next;
      sym_valid_reg <= sym_valid_next;
      is_comma_reg  <= is_comma_next;
      locked_reg    <= locked_next;
      align_err_reg <= align_err_next;
    end
  end

  assign sym_out   = sym_out_reg;
  assign sym_valid = sym_valid_reg;
  assign is_comma  = is_comma_reg;
  assign locked    = locked_reg;
  assign align_err = align_err_reg;

endmodule

// File: tb/tb_des_align.sv
// Bench for des_align: bit-stream stimulus, a bit-history reference model that
// queues expected output events, and a monitor that checks every DUT event.
module tb_des_align;

  localparam logic [9:0] K_NEG = 10'b0011111010;
  localparam logic [9:0] K_POS = 10'b1100000101;
  localparam logic [9:0] D215  = 10'b1010101010;
  localparam int LOCK_COMMAS = 3;
  localparam int LOSS_COMMAS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b0;
  logic [9:0] sym_out;
  logic       sym_valid, is_comma, locked, align_err;

  des_align dut (
    .clk(clk), .rst(rst), .serial_in(serial_in),
    .sym_out(sym_out), .sym_valid(sym_valid), .is_comma(is_comma),
    .locked(locked), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [9:0] sym;
    logic       valid;
    logic       comma;
    logic       aerr;
    logic       lk;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic rst_edge = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: history of received bits, alignment tracked as the cycle
  // index of the last anchoring comma; boundaries every 10 cycles after it.
  logic bits_q[$];
  int   mode = 0;  // 0 hunting, 1 synchronising, 2 locked
  int   anchor = 0, ccnt = 0, ecnt = 0;
  logic locked_out = 1'b0;
  logic [9:0] last_sym = '0;

  task automatic model_step(input int k);
    logic [9:0] w;
    logic m, bnd, v, ae, lose, nl;
    w = '0;
    for (int i = 0; i < 10; i++)
      if (bits_q.size() > i) w[i] = bits_q[bits_q.size() - 1 - i];
    m    = (w == K_NEG) || (w == K_POS);
    bnd  = (mode != 0) && (k > anchor) && (((k - anchor) % 10) == 0);
    v    = 1'b0;
    ae   = 1'b0;
    lose = 1'b0;
    if (mode == 0) begin
      if (m) begin
        v = 1'b1; anchor = k; ccnt = 1; ecnt = 0;
        mode = (LOCK_COMMAS == 1) ? 2 : 1;
      end
    end else if (mode == 1) begin
      if (bnd) begin
        v = 1'b1;
        if (m) begin
          ccnt++;
          if (ccnt == LOCK_COMMAS) begin mode = 2; ecnt = 0; end
        end
      end else if (m) begin
        v = 1'b1; anchor = k; ccnt = 1;
      end
    end else begin
      if (bnd) begin
        v = 1'b1;
        if (m) ecnt = 0;
      end else if (m) begin
        ae = 1'b1;
        ecnt++;
        if (ecnt == LOSS_COMMAS) begin
          mode = 0; ccnt = 0; ecnt = 0; lose = 1'b1;
        end
      end
    end
    nl = (mode == 2) || lose;
    if (v) last_sym = w;
    if (v || ae || (nl != locked_out)) begin
      ev_t e;
      e.cyc = k + 1; e.sym = last_sym; e.valid = v; e.comma = v && m;
      e.aerr = ae; e.lk = nl;
      exp_q.push_back(e);
    end
    locked_out = nl;
  endtask

  always begin
    @(posedge clk);
    #1;
    rst_edge = rst;
    if (rst) begin
      bits_q.delete();
      mode = 0; anchor = 0; ccnt = 0; ecnt = 0;
      locked_out = 1'b0; last_sym = '0;
      while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
    end else begin
      bits_q.push_back(serial_in);
      model_step(cyc);
    end
  end

  // Monitor: compares every output event against the queued expectation.
  logic prev_locked = 1'b0;
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_edge) begin
        checks++;
        if (sym_out !== '0 || sym_valid !== 1'b0 || is_comma !== 1'b0 ||
            locked !== 1'b0 || align_err !== 1'b0) begin
          errors++;
          $display("FAIL reset_state cyc=%0d got sym=%b v=%b c=%b lk=%b ae=%b want all 0",
                   cyc, sym_out, sym_valid, is_comma, locked, align_err);
        end
        prev_locked = 1'b0;
      end else begin
        logic exp_ev, dut_ev;
        exp_ev = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
        dut_ev = sym_valid || align_err || (locked !== prev_locked);
        if (exp_ev || dut_ev) begin
          checks++;
          if (!exp_ev) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d got sym=%b v=%b c=%b lk=%b ae=%b want no event",
                     cyc, sym_out, sym_valid, is_comma, locked, align_err);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || sym_out !== e.sym || sym_valid !== e.valid ||
                is_comma !== e.comma || align_err !== e.aerr || locked !== e.lk) begin
              errors++;
              $display("FAIL event cyc=%0d got sym=%b v=%b c=%b lk=%b ae=%b want cyc=%0d sym=%b v=%b c=%b lk=%b ae=%b",
                       cyc, sym_out, sym_valid, is_comma, locked, align_err,
                       e.cyc, e.sym, e.valid, e.comma, e.lk, e.aerr);
            end else begin
              $display("ok cyc=%0d sym=%b v=%b c=%b lk=%b ae=%b",
                       cyc, sym_out, sym_valid, is_comma, locked, align_err);
            end
          end
        end
        prev_locked = locked;
      end
    end
  end

  // Stimulus
  int stream_idx = 0;

  task automatic send_bit(input logic b);
    serial_in = b;
    @(negedge clk);
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) send_bit(s[i]);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic send_stream(input int n, input logic rnd_data);
    for (int i = 0; i < n; i++) begin
      if (stream_idx % 2 == 0)
        send_sym(((stream_idx / 2) % 2 == 0) ? K_NEG : K_POS);
      else
        send_sym(rnd_data ? 10'($urandom_range(0, 1023)) : D215);
      stream_idx++;
    end
  endtask

  initial begin
    logic [9:0] sym_tmp;
    @(negedge clk);
    // Reset with random serial data
    rst = 1'b1;
    send_rand(3);
    rst = 1'b0;
    // Acquire lock after random preamble
    send_rand(7);
    stream_idx = 0;
    send_stream(12, 1'b0);
    // Tolerated glitch: one comma off the boundary, phase preserved
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_sym(K_NEG);
    for (int i = 0; i < 7; i++) send_bit(1'(i % 2));
    send_stream(6, 1'b0);
    // Loss of lock: slip 4 bits, misaligned commas, then reacquire
    send_rand(4);
    send_stream(16, 1'b0);
    // Reset mid-symbol while locked
    sym_tmp = (stream_idx % 2 == 0) ? K_NEG : D215;
    for (int i = 9; i >= 5; i--) send_bit(sym_tmp[i]);
    rst = 1'b1;
    send_bit(1'b0);
    rst = 1'b0;
    send_rand(2);
    stream_idx = 0;
    send_stream(10, 1'b0);
    // Realign in SYNC: two aligned commas, then a 3-bit slip
    rst = 1'b1;
    send_rand(2);
    rst = 1'b0;
    stream_idx = 0;
    send_stream(4, 1'b0);
    send_rand(3);
    send_stream(10, 1'b0);
    // Randomised slips and data
    for (int r = 0; r < 8; r++) begin
      send_rand($urandom_range(0, 9));
      send_stream($urandom_range(4, 14), 1'($urandom_range(0, 1)));
    end
    send_rand(15);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d pending events want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
